addi_exec_core: RTL and testbench



---
 rtl/addi_exec_if.sv | 40 ++++
 rtl/addi_exec_core.sv | 73 +++++++
 tb/tb_addi_exec_core.sv | 138 +++++++++++++
 3 files changed

// File: rtl/addi_exec_if.sv
// Instruction-in / result-out bundle for addi_exec_core.
// ADDI_EXEC_EBREAK_EN adds the ebreak indication.
interface addi_exec_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           inst;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  reg_wen;
  logic                  illegal;
  logic [ADDR_WIDTH-1:0] dbg_raddr;
  logic [DATA_WIDTH-1:0] dbg_rdata;
`ifdef ADDI_EXEC_EBREAK_EN
  logic                  ebreak;
`endif

  modport master (
    output inst,
    output dbg_raddr,
    input  alu_result,
    input  reg_wen,
    input  illegal,
`ifdef ADDI_EXEC_EBREAK_EN
    input  ebreak,
`endif
    input  dbg_rdata
  );

  modport slave (
    input  inst,
    input  dbg_raddr,
    output alu_result,
    output reg_wen,
    output illegal,
`ifdef ADDI_EXEC_EBREAK_EN
    output ebreak,
`endif
    output dbg_rdata
  );
endinterface

// File: rtl/addi_exec_core.sv
// Single-cycle ADDI decode/execute/writeback with a 2**ADDR_WIDTH entry register file.
// Optional: define ADDI_EXEC_EBREAK_EN to decode EBREAK as legal and drive bus.ebreak.
module addi_exec_core #(
  parameter int                    ADDR_WIDTH  = 5,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input logic        clk,
  input logic        rst,
  addi_exec_if.slave bus
);

  localparam int          NUM_REGS    = 2 ** ADDR_WIDTH;
  localparam logic [6:0]  OP_IMM      = 7'b0010011;
  localparam logic [2:0]  F3_ADDI     = 3'b000;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] rd;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  is_addi;
  logic                  is_ebreak;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    opcode    = bus.inst[6:0];
    funct3    = bus.inst[14:12];
    rd        = bus.inst[7 +: ADDR_WIDTH];
    rs1       = bus.inst[15 +: ADDR_WIDTH];
    imm       = {{(DATA_WIDTH - 12){bus.inst[31]}}, bus.inst[31:20]};
    is_addi   = (opcode == OP_IMM) && (funct3 == F3_ADDI);
    is_ebreak = 1'b0;
`ifdef ADDI_EXEC_EBREAK_EN
    is_ebreak = (bus.inst == EBREAK_INST);
`else
    // Without the feature, EBREAK falls through to illegal like any other non-ADDI word.
    is_ebreak = is_ebreak && (bus.inst == EBREAK_INST);
`endif
  end

  // x0 is hardwired to zero on both read ports regardless of its storage contents.
  always_comb begin
    rdata1        = (rs1 == '0) ? '0 : regs[rs1];
    bus.dbg_rdata = (bus.dbg_raddr == '0) ? '0 : regs[bus.dbg_raddr];
  end

  always_comb begin
    bus.alu_result = rdata1 + imm;
    bus.reg_wen    = is_addi;
    bus.illegal    = !(is_addi || is_ebreak);
`ifdef ADDI_EXEC_EBREAK_EN
    bus.ebreak     = is_ebreak;
`endif
  end

  // NOTE: state uses non-blocking assignments so every read in this cycle sees pre-edge values.
  // NOTE: the register file is reset explicitly, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VALUE;
      end
    end else if (bus.reg_wen && (rd != '0)) begin
      regs[rd] <= bus.alu_result;
    end
  end

endmodule

// File: tb/tb_addi_exec_core.sv
// Scoreboard bench for addi_exec_core: directed plan cases plus randomized ADDI traffic
// checked against an architectural register-array model.
module tb_addi_exec_core;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] alu;
    logic        wen;
    logic        ill;
    logic        ebk;
    logic [31:0] dbg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  addi_exec_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  addi_exec_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_VALUE('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb_q[$];
  logic [31:0] ref_regs [32];
  int          n_tests = 0;
  int          n_fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input logic [31:0] inst);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (inst %h)", name, act, exp, inst);
    end
  endtask

  // Architectural view: x0 reads zero, ADDI writes rd unless rd is x0, reset clears everything.
  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    return (idx == 0) ? 32'h0 : ref_regs[idx];
  endfunction

  task automatic cycle(input logic r, input logic [31:0] i, input logic [4:0] da, input bit chk);
    exp_t e;
    logic addi;
    @(posedge clk);
    #1;
    rst           = r;
    bus.inst      = i;
    bus.dbg_raddr = da;
    addi   = (i[6:0] == 7'h13) && (i[14:12] == 3'h0);
    e.inst = i;
    e.alu  = ref_read(i[19:15]) + 32'($signed(i[31:20]));
    e.wen  = addi;
`ifdef ADDI_EXEC_EBREAK_EN
    e.ebk  = (i == 32'h0010_0073);
`else
    e.ebk  = 1'b0;
`endif
    e.ill  = !(addi || e.ebk);
    e.dbg  = ref_read(da);
    if (chk) sb_q.push_back(e);
    if (r) begin
      for (int k = 0; k < 32; k++) ref_regs[k] = 32'h0;
    end else if (addi && i[11:7] != 0) begin
      ref_regs[i[11:7]] = e.alu;
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("alu_result", bus.alu_result, e.alu, e.inst);
      check("reg_wen", 32'(bus.reg_wen), 32'(e.wen), e.inst);
      check("illegal", 32'(bus.illegal), 32'(e.ill), e.inst);
      check("dbg_rdata", bus.dbg_rdata, e.dbg, e.inst);
`ifdef ADDI_EXEC_EBREAK_EN
      check("ebreak", 32'(bus.ebreak), 32'(e.ebk), e.inst);
`endif
    end
  end

  initial begin
    logic [31:0] ri;
    int          sel;
    rst           = 1'b1;
    bus.inst      = 32'h0;
    bus.dbg_raddr = '0;
    for (int k = 0; k < 32; k++) ref_regs[k] = 32'h0;

    // Pre-reset register contents are unknown, so the reset cycle itself is not scored.
    cycle(1'b1, 32'h0, 5'd0, 1'b0);
    for (int k = 0; k < 32; k++) cycle(1'b0, 32'h0, 5'(k), 1'b1);

    cycle(1'b0, 32'h0050_0093, 5'd1, 1'b1);  // addi x1,x0,5
    cycle(1'b0, 32'hFFF0_8113, 5'd1, 1'b1);  // addi x2,x1,-1
    cycle(1'b0, 32'hFFF0_0193, 5'd2, 1'b1);  // addi x3,x0,-1
    cycle(1'b0, 32'h0011_8193, 5'd3, 1'b1);  // addi x3,x3,1 -> wraps to 0
    cycle(1'b0, 32'h0070_0013, 5'd3, 1'b1);  // addi x0,x0,7
    cycle(1'b0, 32'h0010_0073, 5'd0, 1'b1);  // ebreak
    cycle(1'b0, 32'h0030_0213, 5'd2, 1'b1);  // addi x4,x0,3
    cycle(1'b0, 32'h0000_0000, 5'd4, 1'b1);
    cycle(1'b1, 32'h0090_0213, 5'd4, 1'b1);  // reset wins over addi x4,x0,9
    cycle(1'b0, 32'h0000_0000, 5'd4, 1'b1);
    cycle(1'b0, 32'h0000_0000, 5'd1, 1'b1);

    for (int n = 0; n < 2000; n++) begin
      ri  = $urandom;
      sel = $urandom_range(0, 99);
      if (sel < 70) begin
        ri[6:0]   = 7'h13;
        ri[14:12] = 3'h0;
      end else if (sel < 76) begin
        ri = 32'h0010_0073;
      end else if (sel < 86) begin
        ri[6:0] = 7'h13;
      end
      cycle(($urandom_range(0, 99) == 0), ri, 5'($urandom_range(0, 31)), 1'b1);
    end

    @(negedge clk);
    for (int w = 0; w < 10 && sb_q.size() != 0; w++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fails++;
      $display("FAIL drain: %0d expected responses never checked", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
